elastic_rr_merge: RTL and testbench

ELASTIC_RR_MERGE -- requirements
Module: elastic_rr_merge

---
 rtl/cgra_pkg.sv | 19 +
 rtl/cgra_mux.sv | 25 ++
 rtl/elastic_rr_merge.sv | 121 ++++++++++++
 tb/tb_elastic_rr_merge.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_pkg.sv
// Shared CGRA definitions: channel-count limits for multi-input blocks and the
// elastic (valid/ready) handshake pair used across the fabric.
package cgra_pkg;

    localparam int unsigned CGRA_MIN_INPUTS = 2;
    localparam int unsigned CGRA_MAX_INPUTS = 16;

    // One elastic handshake channel as seen at a single interface point.
    typedef struct packed {
        logic valid;
        logic ready;
    } elastic_hs_t;

    // A token moves across the channel in any cycle where both sides agree.
    function automatic logic elastic_fire(elastic_hs_t hs);
        return hs.valid && hs.ready;
    endfunction

endpackage

// File: rtl/cgra_mux.sv
// Shared CGRA N:1 word mux.
// Ports: sel       - channel index
//        data_in   - NUM_INPUTS packed words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//        data_out_c- selected word (combinational); zero for an out-of-range sel
module cgra_mux #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned SEL_W = $clog2(NUM_INPUTS)
) (
    input  logic [SEL_W-1:0]                 sel,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0]            data_out_c
);

    // Compare-and-select so a non power-of-two channel count never reads past the bus.
    always_comb begin
        data_out_c = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (sel == SEL_W'(i)) begin
                data_out_c = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: rtl/elastic_rr_merge.sv
// Round-robin merge of NUM_INPUTS elastic channels into one registered elastic
// output stage. Full throughput: the output register drains and reloads in the
// same cycle.
// Ports: clk, rst_n (async, active-low)
//        data_in/valid_in/ready_out - NUM_INPUTS upstream channels
//        data_out/valid_out/ready_in - merged downstream channel (registered)
//        grant_idx                  - source channel of the token in data_out
//        xfer_cnt                   - output transfer count, only when
//                                     ELASTIC_RR_MERGE_STATS_EN is defined
module elastic_rr_merge
    import cgra_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned IDX_W = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_INPUTS-1:0]            valid_in,
    output logic [NUM_INPUTS-1:0]            ready_out,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             valid_out,
    input  logic                             ready_in,
    output logic [IDX_W-1:0]                 grant_idx
`ifdef ELASTIC_RR_MERGE_STATS_EN
    ,
    output logic [31:0]                      xfer_cnt
`endif
);

    localparam int unsigned SUM_W = IDX_W + 1;

    if (NUM_INPUTS < CGRA_MIN_INPUTS || NUM_INPUTS > CGRA_MAX_INPUTS) begin : g_bad_cfg
        $error("elastic_rr_merge: NUM_INPUTS out of supported range");
    end

    elastic_hs_t             out_hs_c;
    logic                    load_c;
    logic                    out_fire_c;
    logic                    in_fire_c;
    logic                    any_valid_c;
    logic [IDX_W-1:0]        grant_c;
    logic [DATA_WIDTH-1:0]   mux_data_c;
    logic [IDX_W-1:0]        ptr_q;

    assign out_hs_c   = '{valid: valid_out, ready: ready_in};
    assign out_fire_c = elastic_fire(out_hs_c);
    // Output register can accept a token if it is empty or being drained now.
    assign load_c     = !valid_out || ready_in;
    assign in_fire_c  = load_c && any_valid_c;

    // Rotating search from ptr_q; the wrap is a subtract so it stays in range
    // for any channel count.
    always_comb begin
        logic [SUM_W-1:0] sum;
        sum         = '0;
        grant_c     = '0;
        any_valid_c = 1'b0;
        for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            sum = {1'b0, ptr_q} + SUM_W'(k);
            if (sum >= SUM_W'(NUM_INPUTS)) begin
                sum = sum - SUM_W'(NUM_INPUTS);
            end
            if (!any_valid_c && valid_in[sum[IDX_W-1:0]]) begin
                any_valid_c = 1'b1;
                grant_c     = sum[IDX_W-1:0];
            end
        end
    end

    // Only the granted channel sees ready.
    always_comb begin
        ready_out = '0;
        if (in_fire_c) begin
            ready_out[grant_c] = 1'b1;
        end
    end

    cgra_mux #(
        .NUM_INPUTS (NUM_INPUTS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mux (
        .sel        (grant_c),
        .data_in    (data_in),
        .data_out_c (mux_data_c)
    );

    // Output stage and priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            grant_idx <= '0;
            ptr_q     <= '0;
        end else if (in_fire_c) begin
            valid_out <= 1'b1;
            data_out  <= mux_data_c;
            grant_idx <= grant_c;
            if (grant_c == IDX_W'(NUM_INPUTS - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= grant_c + IDX_W'(1);
            end
        end else if (out_fire_c) begin
            valid_out <= 1'b0;
        end
    end

`ifdef ELASTIC_RR_MERGE_STATS_EN
    // Free-running output transfer count, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (out_fire_c) begin
            xfer_cnt <= xfer_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_elastic_rr_merge.sv
module tb_elastic_rr_merge;

    localparam int N  = 4;
    localparam int DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [N*DW-1:0] data_in;
    logic [N-1:0]    valid_in;
    logic [N-1:0]    ready_out;
    logic [DW-1:0]   data_out;
    logic            valid_out;
    logic            ready_in;
    logic [1:0]      grant_idx;
`ifdef ELASTIC_RR_MERGE_STATS_EN
    logic [31:0]     xfer_cnt;
    logic [31:0]     xfer_cnt3;
`endif

    logic [23:0]     d3_in;
    logic [2:0]      v3_in;
    logic [2:0]      r3_out;
    logic [7:0]      d3_out;
    logic            v3_out;
    logic            r3_in;
    logic [1:0]      g3;

    elastic_rr_merge #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .grant_idx (grant_idx)
`ifdef ELASTIC_RR_MERGE_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    elastic_rr_merge #(.NUM_INPUTS(3), .DATA_WIDTH(8)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (d3_in),
        .valid_in  (v3_in),
        .ready_out (r3_out),
        .data_out  (d3_out),
        .valid_out (v3_out),
        .ready_in  (r3_in),
        .grant_idx (g3)
`ifdef ELASTIC_RR_MERGE_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt3)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a one-slot buffer fed by a rotating-priority pick.
    logic          m_vout;
    logic [DW-1:0] m_data;
    int            m_g;
    int            m_ptr;
    logic [31:0]   m_cnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_vout = 1'b0;
        m_data = '0;
        m_g    = 0;
        m_ptr  = 0;
        m_cnt  = '0;
    endtask

    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Called at posedge+1; applies one cycle of stimulus and checks against the model.
    task automatic step(input logic [N-1:0] v, input logic r, input logic [N*DW-1:0] d,
                        output logic [N-1:0] rdy_seen);
        int         g;
        logic       load;
        logic [N-1:0] er;
        valid_in = v;
        ready_in = r;
        data_in  = d;
        #1;
        load = !m_vout || r;
        g    = model_grant(v);
        er   = '0;
        if (load && g >= 0) er[g] = 1'b1;
        rdy_seen = ready_out;
        chk("ready_out", 64'(ready_out), 64'(er));
        @(posedge clk);
        #1;
        if (m_vout && r) m_cnt = m_cnt + 32'd1;
        if (load && g >= 0) begin
            m_data = d[g*DW +: DW];
            m_g    = g;
            m_vout = 1'b1;
            m_ptr  = (g + 1) % N;
        end else if (m_vout && r) begin
            m_vout = 1'b0;
        end
        chk("valid_out", 64'(valid_out), 64'(m_vout));
        chk("data_out", 64'(data_out), 64'(m_data));
        chk("grant_idx", 64'(grant_idx), 64'(m_g));
`ifdef ELASTIC_RR_MERGE_STATS_EN
        chk("xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
`endif
    endtask

    typedef struct {
        logic [N-1:0]    v;
        logic            r;
        logic [N*DW-1:0] d;
        logic [N-1:0]    er;
        logic            ev;
        logic [1:0]      eg;
        logic [DW-1:0]   ed;
    } vec_t;

    vec_t tbl[10];

    task automatic step3(input logic [2:0] v, input logic [2:0] er, input logic [1:0] eg,
                         input logic [7:0] ed);
        v3_in = v;
        #1;
        chk("n3 ready_out", 64'(r3_out), 64'(er));
        @(posedge clk);
        #1;
        chk("n3 grant_idx", 64'(g3), 64'(eg));
        chk("n3 data_out", 64'(d3_out), 64'(ed));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*DW-1:0] base;
        logic [N*DW-1:0] beef;
        logic [N-1:0]    rs;
        logic [DW-1:0]   held_d;
        int              held_g;

        base = {32'h0000_1103, 32'h0000_1102, 32'h0000_1101, 32'h0000_1100};
        beef = {32'h0000_1103, 32'hDEAD_BEEF, 32'h0000_1101, 32'h0000_1100};

        //         v        r     d     ready    vout  g      data
        tbl[0] = '{4'b1111, 1'b1, base, 4'b0001, 1'b1, 2'd0, 32'h0000_1100};
        tbl[1] = '{4'b1111, 1'b1, base, 4'b0010, 1'b1, 2'd1, 32'h0000_1101};
        tbl[2] = '{4'b1111, 1'b1, base, 4'b0100, 1'b1, 2'd2, 32'h0000_1102};
        tbl[3] = '{4'b1111, 1'b1, base, 4'b1000, 1'b1, 2'd3, 32'h0000_1103};
        tbl[4] = '{4'b1111, 1'b1, base, 4'b0001, 1'b1, 2'd0, 32'h0000_1100};
        tbl[5] = '{4'b0100, 1'b1, beef, 4'b0100, 1'b1, 2'd2, 32'hDEAD_BEEF};
        tbl[6] = '{4'b0000, 1'b1, beef, 4'b0000, 1'b0, 2'd2, 32'hDEAD_BEEF};
        tbl[7] = '{4'b1010, 1'b0, base, 4'b1000, 1'b1, 2'd3, 32'h0000_1103};
        tbl[8] = '{4'b1111, 1'b0, base, 4'b0000, 1'b1, 2'd3, 32'h0000_1103};
        tbl[9] = '{4'b0011, 1'b1, base, 4'b0001, 1'b1, 2'd0, 32'h0000_1100};

        valid_in = '0;
        ready_in = 1'b0;
        data_in  = '0;
        v3_in    = '0;
        r3_in    = 1'b1;
        d3_in    = {8'h32, 8'h31, 8'h30};
        model_reset();

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("reset valid_out", 64'(valid_out), 64'(0));
        chk("reset data_out", 64'(data_out), 64'(0));
        chk("reset grant_idx", 64'(grant_idx), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors from reset.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].r, tbl[i].d, rs);
            chk($sformatf("vec%0d ready_out", i), 64'(rs), 64'(tbl[i].er));
            chk($sformatf("vec%0d valid_out", i), 64'(valid_out), 64'(tbl[i].ev));
            chk($sformatf("vec%0d grant_idx", i), 64'(grant_idx), 64'(tbl[i].eg));
            chk($sformatf("vec%0d data_out", i), 64'(data_out), 64'(tbl[i].ed));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                 {$urandom, $urandom, $urandom, $urandom}, rs);
        end

        // Back-pressure: output held while downstream stalls, then drain+reload.
        step(4'b1111, 1'b1, base, rs);
        held_d = m_data;
        held_g = m_g;
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0, {$urandom, $urandom, $urandom, $urandom}, rs);
            chk("stall ready_out", 64'(rs), 64'(0));
            chk("stall data_out", 64'(data_out), 64'(held_d));
            chk("stall grant_idx", 64'(grant_idx), 64'(held_g));
        end
        step(4'b1111, 1'b1, base, rs);
        chk("reload valid_out", 64'(valid_out), 64'(1));
        chk("reload grant_idx", 64'(grant_idx), 64'((held_g + 1) % N));

        // Reset mid-stream between edges with pointer away from 0.
        step(4'b0001, 1'b1, base, rs);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset valid_out", 64'(valid_out), 64'(0));
        chk("midreset data_out", 64'(data_out), 64'(0));
        chk("midreset grant_idx", 64'(grant_idx), 64'(0));
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(4'b1111, 1'b1, base, rs);
        chk("post-reset ready_out", 64'(rs), 64'(4'b0001));
        chk("post-reset grant_idx", 64'(grant_idx), 64'(0));

`ifdef ELASTIC_RR_MERGE_STATS_EN
        // Transfer counting with stalls, then wrap.
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(4'b1111, 1'b1, base, rs);
        for (int i = 0; i < 13; i++) begin
            step(4'b1111, 1'((i % 4) != 1), base, rs);
        end
        chk("stats count 10", 64'(xfer_cnt), 64'(10));
        force dut.xfer_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.xfer_cnt;
        m_cnt = 32'hFFFF_FFFE;
        step(4'b1111, 1'b1, base, rs);
        step(4'b1111, 1'b1, base, rs);
        chk("stats wrap", 64'(xfer_cnt), 64'(0));
`endif

        // Three-channel instance: sparse valids, wrap past the last channel.
        step3(3'b001, 3'b001, 2'd0, 8'h30);
        step3(3'b101, 3'b100, 2'd2, 8'h32);
        step3(3'b101, 3'b001, 2'd0, 8'h30);
        step3(3'b101, 3'b100, 2'd2, 8'h32);
        for (int i = 0; i < 40; i++) begin
            v3_in = 3'($urandom_range(0, 7));
            r3_in = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk("n3 grant range", 64'(g3 < 2'd3), 64'(1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
